// File: rtl/layer_sequencer.sv
// layer_sequencer: feeds one input vector through M passes of a shared external layer and returns the result.
// Optional WAIT watchdog (timeout -> zero result and err) is enabled by defining LAYER_TIMEOUT_EN.
module layer_sequencer #(
    parameter int N       = 4,
    parameter int M       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [N*16-1:0]                     in_x,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [N*16-1:0]                     out_y,
    output logic                                layer_start,
    output logic [N*16-1:0]                     layer_x,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] layer_idx,
    input  logic [N*16-1:0]                     layer_y,
    input  logic                                layer_done,
    output logic                                busy,
    output logic                                err
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t              state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [N*16-1:0]     act, act_n;
    logic                in_ready_n;
    logic                out_valid_n;
    logic [N*16-1:0]     out_y_n;
    logic                layer_start_n;
    logic [N*16-1:0]     layer_x_n;
    logic [IW-1:0]       layer_idx_n;
    logic                busy_n;

`ifdef LAYER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0]       tcnt, tcnt_n;
    logic                err_q, err_n;

    assign err = err_q;
`else
    // Without the watchdog there is nothing that can time out.
    assign err = 1'b0;

    // TIMEOUT is only consumed by the watchdog build.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            act         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_y       <= '0;
            layer_start <= 1'b0;
            layer_x     <= '0;
            layer_idx   <= '0;
            busy        <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
            tcnt        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            act         <= act_n;
            in_ready    <= in_ready_n;
            out_valid   <= out_valid_n;
            out_y       <= out_y_n;
            layer_start <= layer_start_n;
            layer_x     <= layer_x_n;
            layer_idx   <= layer_idx_n;
            busy        <= busy_n;
`ifdef LAYER_TIMEOUT_EN
            tcnt        <= tcnt_n;
            err_q       <= err_n;
`endif
        end
    end

    // Every output is computed one cycle ahead from the next state so it registers cleanly.
    always_comb begin
        state_n       = state;
        idx_n         = idx;
        act_n         = act;
        out_valid_n   = out_valid;
        out_y_n       = out_y;
        layer_start_n = 1'b0;
        layer_x_n     = layer_x;
        layer_idx_n   = layer_idx;
`ifdef LAYER_TIMEOUT_EN
        tcnt_n        = tcnt;
        err_n         = err_q;
`endif

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    act_n         = in_x;
                    idx_n         = '0;
                    layer_start_n = 1'b1;
                    layer_x_n     = in_x;
                    layer_idx_n   = '0;
                    state_n       = START;
`ifdef LAYER_TIMEOUT_EN
                    err_n         = 1'b0;
`endif
                end
            end

            START: begin
                // A layer_done coinciding with the start pulse belongs to nothing and is dropped.
                state_n = WAIT;
`ifdef LAYER_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end

            WAIT: begin
                if (layer_done) begin
                    act_n = layer_y;
                    if (idx == LAST) begin
                        state_n = OUT;
                    end else begin
                        idx_n         = idx + IW'(1);
                        layer_start_n = 1'b1;
                        layer_x_n     = layer_y;
                        layer_idx_n   = idx + IW'(1);
                        state_n       = START;
                    end
                end
`ifdef LAYER_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    act_n   = '0;
                    err_n   = 1'b1;
                    state_n = OUT;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
`endif
            end

            OUT: begin
                // out_valid trails entry into OUT by one cycle; act is frozen here so out_y stays stable.
                if (out_valid && out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end else begin
                    out_valid_n = 1'b1;
                    out_y_n     = act;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n = (state_n == IDLE);
        busy_n     = (state_n != IDLE);
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: directed vectors, +1-per-lane layer model with D=3.
module tb_layer_sequencer;

    localparam int N  = 4;
    localparam int M  = 4;
    localparam int D  = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*16-1:0]   in_x;
    logic              out_valid;
    logic              out_ready;
    logic [N*16-1:0]   out_y;
    logic              layer_start;
    logic [N*16-1:0]   layer_x;
    logic [IW-1:0]     layer_idx;
    logic [N*16-1:0]   layer_y;
    logic              layer_done;
    logic              busy;
    logic              err;

    logic              model_on;
    logic              model_done;
    logic              extra_done;
    logic [N*16-1:0]   model_y;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [N*16-1:0] y;
        logic            e;
    } exp_t;

    exp_t        exp_q[$];
    logic [IW-1:0] idx_q[$];

    always #5 clk = ~clk;

    layer_sequencer #(
        .N(N),
        .M(M),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y),
        .layer_start(layer_start),
        .layer_x(layer_x),
        .layer_idx(layer_idx),
        .layer_y(layer_y),
        .layer_done(layer_done),
        .busy(busy),
        .err(err)
    );

    assign layer_y    = model_y;
    assign layer_done = model_done | extra_done;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [N*16-1:0] vec(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [N*16-1:0] plus1(input logic [N*16-1:0] v);
        logic [N*16-1:0] r;
        for (int i = 0; i < N; i++) r[16*i +: 16] = v[16*i +: 16] + 16'd1;
        return r;
    endfunction

    // Shared-layer model: answers D cycles after it sees the start pulse.
    always @(posedge clk) begin
        logic go;
        int   mcnt;
        logic [N*16-1:0] mx;
        go = 1'b0;
        if (rst) begin
            mcnt = 0;
        end else if (layer_start && model_on) begin
            mx   = layer_x;
            mcnt = D - 1;
            go   = (mcnt == 0);
        end else if (mcnt > 0) begin
            mcnt--;
            go = (mcnt == 0);
        end
        #1;
        model_done = go;
        if (go) model_y = plus1(mx);
    end

    // Monitor: compares every accepted output and every start pulse against the queues.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %0h expected none", out_y);
            end else begin
                e = exp_q.pop_front();
                check("out_y", out_y, e.y);
                check("out_err", err, e.e);
            end
        end
        if (!rst && layer_start) begin
            if (idx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_start: got idx %0d expected none", layer_idx);
            end else begin
                check("layer_idx", layer_idx, idx_q.pop_front());
            end
        end
    end

    task automatic push_exp(input logic [N*16-1:0] y, input logic e, input int passes);
        exp_t x;
        x.y = y;
        x.e = e;
        exp_q.push_back(x);
        for (int i = 0; i < passes; i++) idx_q.push_back(IW'(i));
    endtask

    // Offer a vector and hold it until accepted; waited = edges until acceptance.
    task automatic offer(input logic [N*16-1:0] v, output int waited);
        in_x     = v;
        in_valid = 1'b1;
        waited   = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            waited++;
            if (in_ready) break;
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic measure(output int cyc);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) check("idle_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_y"}, out_y, 0);
        check({tag, "_layer_start"}, layer_start, 0);
        check({tag, "_layer_x"}, layer_x, 0);
        check({tag, "_layer_idx"}, layer_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, w;
        logic seen;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_x       = '0;
        out_ready  = 1'b1;
        model_on   = 1'b1;
        extra_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Basic pass: {1,2,3,4} through four +1 layers.
        push_exp(vec(5, 6, 7, 8), 1'b0, M);
        offer(vec(1, 2, 3, 4), w);
        measure(c);
        check("latency_basic", c, 17);
        wait_idle();

        // Back-pressure: out_ready low for 10 cycles, lane 3 wraps.
        out_ready = 1'b0;
        push_exp(vec(14, 1, 4, -32765), 1'b0, M);
        offer(vec(10, -3, 0, 32767), w);
        measure(c);
        check("latency_stall", c, 17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_y", out_y, vec(14, 1, 4, -32765));
            check("stall_in_ready", in_ready, 0);
        end
        @(posedge clk) #1 out_ready = 1'b1;
        @(posedge clk) #1;
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Second vector held during operation: accepted only once back in IDLE.
        push_exp(vec(104, 204, 3, -96), 1'b0, M);
        push_exp(vec(4, 4, 4, 4), 1'b0, M);
        offer(vec(100, 200, -1, -100), w);
        offer(vec(0, 0, 0, 0), w);
        check("second_accept_wait", w, 19);
        wait_idle();

        // Spurious layer_done in IDLE and during the start pulse.
        extra_done = 1'b1;
        @(posedge clk) #1 extra_done = 1'b0;
        check("idle_done_busy", busy, 0);
        check("idle_done_in_ready", in_ready, 1);
        check("idle_done_start", layer_start, 0);
        push_exp(vec(11, 12, 13, 14), 1'b0, M);
        offer(vec(7, 8, 9, 10), w);
        extra_done = 1'b1;
        @(posedge clk) #1 extra_done = 1'b0;
        measure(c);
        check("latency_spur", c, 16);
        wait_idle();

        // Reset during WAIT of layer 2, then a stray layer_done.
        idx_q.push_back(IW'(0));
        idx_q.push_back(IW'(1));
        idx_q.push_back(IW'(2));
        offer(vec(50, 50, 50, 50), w);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && layer_idx == IW'(2) && !layer_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("reach_layer2_wait", seen, 1);
        rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1 extra_done = 1'b1;
        repeat (2) @(posedge clk);
        #1 extra_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("abort_no_activity", seen, 0);
        check_reset_outputs("post_abort");

`ifdef LAYER_TIMEOUT_EN
        // Layer never answers: eight WAIT cycles then a zero result with err.
        @(posedge clk) #1 model_on = 1'b0;
        push_exp('0, 1'b1, 1);
        offer(vec(9, 9, 9, 9), w);
        measure(c);
        check("latency_timeout", c, 10);
        check("timeout_err", err, 1);
        wait_idle();
        check("err_held_idle", err, 1);
        model_on = 1'b1;
        push_exp(vec(0, 1, 2, 3), 1'b0, M);
        offer(vec(-4, -3, -2, -1), w);
        check("err_cleared", err, 0);
        measure(c);
        check("latency_after_timeout", c, 17);
        wait_idle();
`endif

        repeat (5) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("idx_queue_empty", idx_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter N, default 4: neurons per layer; vectors are N lanes of signed 16-bit.
REQ-002 SHALL have parameter M, default 4: number of layers run through one shared layer instance.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles per layer (used only under LAYER_TIMEOUT_EN).
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk, in, 1, rising-edge clock; rst, in, 1, asynchronous active-high reset.
REQ-005 SHALL have ports: in_valid, in, 1, input vector offered; in_ready, out, 1, sequencer can accept; in_x, in, N*16, signed input vector.
REQ-006 SHALL have ports: out_valid, out, 1, result available; out_ready, in, 1, consumer accepts; out_y, out, N*16, signed result vector.
REQ-007 SHALL have ports: layer_start, out, 1, one-cycle start pulse to shared layer; layer_x, out, N*16, layer input; layer_idx, out, max(1,$clog2(M)), weight/bias slice select.
REQ-008 SHALL have ports: layer_y, in, N*16, layer output; layer_done, in, 1, layer result valid; busy, out, 1, high when not IDLE; err, out, 1, timeout flag.

Function
REQ-009 SHALL implement FSM states IDLE, START, WAIT, OUT; all outputs registered.
REQ-010 IDLE: in_ready=1; on in_valid&&in_ready, latch in_x into activation register act, set idx=0, go to START.
REQ-011 START: layer_start=1 for exactly one cycle; layer_x=act, layer_idx=idx; next state WAIT.
REQ-012 WAIT: layer_x and layer_idx held stable; layer_start=0; on layer_done=1, capture layer_y into act.
REQ-013 WAIT with layer_done: idx<M-1 -> idx+1, go to START; idx==M-1 -> go to OUT.
REQ-014 OUT: out_valid=1, out_y=act; out_y stable while out_valid&&!out_ready; on out_ready go to IDLE, out_valid=0 next cycle.
REQ-015 in_ready SHALL be 0 in every state except IDLE; in_valid outside IDLE SHALL be ignored and not lost to the requester (it must hold).
REQ-016 layer_done outside WAIT, including the cycle layer_start is high, SHALL be ignored.
REQ-017 Latency: with layer answering layer_done D>=1 cycles after the WAIT entry, out_valid rises M*(D+1)+1 cycles after the accepting edge.
REQ-018 M=1 SHALL perform one START/WAIT pass with layer_idx=0.
REQ-019 act, out_y, layer_x SHALL pass data bit-exact; no arithmetic on vectors.
REQ-020 busy SHALL equal (state != IDLE).

Reset
REQ-021 On rst: state=IDLE, idx=0, act=0, in_ready=1, out_valid=0, out_y=0, layer_start=0, layer_x=0, layer_idx=0, err=0, timeout counter=0.
REQ-022 rst asserted mid-operation SHALL abort immediately; a pending layer_done after release SHALL be ignored (state IDLE).

Configuration
REQ-023 With macro LAYER_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without layer_done; on reaching TIMEOUT, go to OUT with out_y=0 and err=1.
REQ-024 err SHALL be set only by timeout, held until the next accepted input, then cleared.
REQ-025 Without LAYER_TIMEOUT_EN: no counter logic; err tied 0; WAIT waits indefinitely.

Verification
REQ-026 N=4,M=4; layer model returns x+1 per lane with D=3; in_x={1,2,3,4} -> out_y={5,6,7,8}, layer_idx sequence 0,1,2,3, out_valid 17 cycles after accept.
REQ-027 out_ready held 0 for 10 cycles in OUT -> out_valid and out_y stable, in_ready=0 throughout; accept on release then in_ready=1 next cycle.
REQ-028 in_valid held during operation with a second vector -> not accepted until IDLE; second result correct and in order.
REQ-029 rst pulsed during WAIT of layer 2, then spurious layer_done -> all outputs at reset values, no out_valid.
REQ-030 LAYER_TIMEOUT_EN, TIMEOUT=8, layer never responds -> out_valid with out_y=0, err=1 after 8 WAIT cycles; next accept clears err.
REQ-031 layer_done asserted in same cycle as layer_start and in IDLE -> ignored; idx does not advance.
